// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 16-bit 5-stage pipeline: load-use bubbles,
// branch flush sequencing, data-memory wait holds with timeout, perf counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [2:0]       IFID_RSaddr_i,
  input  logic [2:0]       IFID_RTaddr_i,
  input  logic             IFID_uses_rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic [2:0]       IDEX_RTaddr_i,
  input  logic             EX_taken_i,
  input  logic             MEM_req_i,
  input  logic             MEM_ready_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXWrite_o,
  output logic             hold_o,
  output logic             err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [1:0] FLUSH_REM_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_C      = 8'(TIMEOUT);

  state_t           state_q, state_d, mode;
  logic [1:0]       flush_rem_q, flush_rem_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             memwait, lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign memwait = MEM_req_i & ~MEM_ready_i;
  assign lu = IDEX_MemRead_i & (IDEX_RTaddr_i != 3'd0) &
              ((IDEX_RTaddr_i == IFID_RSaddr_i) |
               (IFID_uses_rt_i & (IDEX_RTaddr_i == IFID_RTaddr_i)));

  always_comb begin
    state_d     = state_q;
    flush_rem_d = flush_rem_q;
    wait_cnt_d  = wait_cnt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IDEXWrite_o = 1'b1;
    IFIDFlush_o = 1'b0;
    hold_o      = 1'b0;
    mode        = state_q;

    // Ready cycle of a wait resumes whatever was interrupted, in the same cycle
    if (state_q == MEM_WAIT && MEM_ready_i) begin
      mode       = (flush_rem_q != 2'd0) ? FLUSH : RUN;
      wait_cnt_d = 8'd0;
    end

    case (mode)
      RUN: begin
        state_d = RUN;
        if (memwait) begin
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          hold_o      = 1'b1;
          stall_inc   = 1'b1;
          wait_cnt_d  = 8'd1;
          state_d     = MEM_WAIT;
        end else if (EX_taken_i) begin
          IFIDFlush_o = 1'b1;
          IDEXWrite_o = 1'b0;
          flush_inc   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_rem_d = FLUSH_REM_INIT;
            state_d     = FLUSH;
          end
        end else if (lu) begin
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          IDEXWrite_o = 1'b0;
          stall_inc   = 1'b1;
        end
      end
      FLUSH: begin
        if (memwait) begin
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          hold_o      = 1'b1;
          stall_inc   = 1'b1;
          wait_cnt_d  = 8'd1;
          state_d     = MEM_WAIT;
        end else begin
          IFIDFlush_o = 1'b1;
          IDEXWrite_o = 1'b0;
          flush_rem_d = flush_rem_q - 2'd1;
          state_d     = (flush_rem_q <= 2'd1) ? RUN : FLUSH;
        end
      end
      MEM_WAIT: begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        hold_o      = 1'b1;
        stall_inc   = 1'b1;
        wait_cnt_d  = wait_cnt_q + 8'd1;
        if (wait_cnt_d == TIMEOUT_C) state_d = ERR;
      end
      default: begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        IDEXWrite_o = 1'b0;
        hold_o      = 1'b1;
      end
    endcase

    if (!rst_n) begin
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      IDEXWrite_o = 1'b1;
      IFIDFlush_o = 1'b0;
      hold_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_rem_q <= 2'd0;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
      wait_cnt_q  <= wait_cnt_d;
      if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_inc) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign err_o       = (state_q == ERR);
  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two parameterisations share stimulus;
// each cycle's expected outputs are queued and checked by a separate monitor.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] rs, rt, idrt;
  logic urt, mr, tk, req, rdy;

  logic a_pcw, a_ifw, a_flu, a_idw, a_hld, a_err;
  logic [1:0] a_st;
  logic [1:0] a_sc, a_fc;
  logic b_pcw, b_ifw, b_flu, b_idw, b_hld, b_err;
  logic [1:0] b_st;
  logic [15:0] b_sc, b_fc;

  // A: two-cycle flush, short timeout, 2-bit counters (saturate at 3)
  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(4), .CNT_W(2)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt),
    .IFID_uses_rt_i(urt), .IDEX_MemRead_i(mr), .IDEX_RTaddr_i(idrt),
    .EX_taken_i(tk), .MEM_req_i(req), .MEM_ready_i(rdy),
    .PCWrite_o(a_pcw), .IFIDWrite_o(a_ifw), .IFIDFlush_o(a_flu),
    .IDEXWrite_o(a_idw), .hold_o(a_hld), .err_o(a_err), .state_o(a_st),
    .stall_cnt_o(a_sc), .flush_cnt_o(a_fc));

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(16), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt),
    .IFID_uses_rt_i(urt), .IDEX_MemRead_i(mr), .IDEX_RTaddr_i(idrt),
    .EX_taken_i(tk), .MEM_req_i(req), .MEM_ready_i(rdy),
    .PCWrite_o(b_pcw), .IFIDWrite_o(b_ifw), .IFIDFlush_o(b_flu),
    .IDEXWrite_o(b_idw), .hold_o(b_hld), .err_o(b_err), .state_o(b_st),
    .stall_cnt_o(b_sc), .flush_cnt_o(b_fc));

  always #5 clk = ~clk;

  // ctl bits: {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, hold}
  localparam logic [4:0] NORM = 5'b11100;
  localparam logic [4:0] LU   = 5'b00000;
  localparam logic [4:0] FL   = 5'b11010;
  localparam logic [4:0] HOLD = 5'b00101;
  localparam logic [4:0] ERRC = 5'b00001;

  typedef struct {
    int         cyc;
    bit         dut;
    logic [4:0] ctl;
    logic       err;
    logic [1:0] st;
    int         sc;
    int         fc;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      logic [7:0] act, req_v;
      int asc, afc;
      me = sbq.pop_front();
      if (me.dut) begin
        act = {b_pcw, b_ifw, b_idw, b_flu, b_hld, b_err, b_st};
        asc = int'(b_sc);
        afc = int'(b_fc);
      end else begin
        act = {a_pcw, a_ifw, a_idw, a_flu, a_hld, a_err, a_st};
        asc = int'(a_sc);
        afc = int'(a_fc);
      end
      req_v = {me.ctl, me.err, me.st};
      checks++;
      if (me.cyc != cyc || act !== req_v || asc != me.sc || afc != me.fc) begin
        errors++;
        $display("FAIL %s (cycle %0d, seen %0d): got ctl/err/st=%b stall=%0d flush=%0d, expected %b stall=%0d flush=%0d",
                 me.name, me.cyc, cyc, act, asc, afc, req_v, me.sc, me.fc);
      end
    end
  end

  task automatic drive(input logic rn, input logic [2:0] i_rs, input logic [2:0] i_rt,
                       input logic i_urt, input logic i_mr, input logic [2:0] i_idrt,
                       input logic i_tk, input logic i_req, input logic i_rdy);
    @(posedge clk);
    #1;
    rst_n = rn; rs = i_rs; rt = i_rt; urt = i_urt; mr = i_mr;
    idrt = i_idrt; tk = i_tk; req = i_req; rdy = i_rdy;
  endtask

  task automatic idle();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_c(input string nm, input bit d, input logic [4:0] ctl,
                          input logic er, input logic [1:0] st, input int sc, input int fc);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.ctl = ctl; e.err = er; e.st = st;
    e.sc = sc; e.fc = fc; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++)
      drive(1'b0, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    expect_c("reset_a", 1'b0, NORM, 1'b0, 2'd0, 0, 0);
    expect_c("reset_b", 1'b1, NORM, 1'b0, 2'd0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; rs = 0; rt = 0; urt = 0; mr = 0; idrt = 0; tk = 0; req = 0; rdy = 0;

    // Reset and idle
    do_reset();
    idle(); expect_c("idle_after_reset", 1'b0, NORM, 1'b0, 2'd0, 0, 0);

    // Load-use detection and its qualifiers
    drive(1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    expect_c("lu_rs_match", 1'b0, LU, 1'b0, 2'd0, 0, 0);
    idle(); expect_c("lu_counted", 1'b0, NORM, 1'b0, 2'd0, 1, 0);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    expect_c("lu_r0_ignored", 1'b0, NORM, 1'b0, 2'd0, 1, 0);
    drive(1'b1, 3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    expect_c("lu_rt_unused", 1'b0, NORM, 1'b0, 2'd0, 1, 0);
    drive(1'b1, 3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    expect_c("lu_rt_used", 1'b0, LU, 1'b0, 2'd0, 1, 0);
    idle(); expect_c("lu_rt_counted", 1'b0, NORM, 1'b0, 2'd0, 2, 0);

    // Taken branch with a simultaneous load-use, two flush cycles
    do_reset();
    drive(1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    expect_c("br_flush1", 1'b0, FL, 1'b0, 2'd0, 0, 0);
    drive(1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    expect_c("br_flush2", 1'b0, FL, 1'b0, 2'd1, 0, 1);
    idle(); expect_c("br_done", 1'b0, NORM, 1'b0, 2'd0, 0, 1);

    // Three-cycle memory wait, then saturation of the 2-bit stall counter
    do_reset();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    expect_c("mw_hold1", 1'b0, HOLD, 1'b0, 2'd0, 0, 0);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    expect_c("mw_hold2", 1'b0, HOLD, 1'b0, 2'd2, 1, 0);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    expect_c("mw_hold3", 1'b0, HOLD, 1'b0, 2'd2, 2, 0);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    expect_c("mw_ready", 1'b0, NORM, 1'b0, 2'd2, 3, 0);
    drive(1'b1, 3'd2, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    expect_c("mw_then_lu", 1'b0, LU, 1'b0, 2'd0, 3, 0);
    idle(); expect_c("stall_saturated", 1'b0, NORM, 1'b0, 2'd0, 3, 0);

    // Timeout into ERR, freeze persists, reset recovers
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      expect_c($sformatf("to_wait%0d", i), 1'b0, HOLD, 1'b0, (i == 0) ? 2'd0 : 2'd2, i, 0);
    end
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    expect_c("to_err", 1'b0, ERRC, 1'b1, 2'd3, 3, 0);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    expect_c("to_err_sticky", 1'b0, ERRC, 1'b1, 2'd3, 3, 0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(); expect_c("to_recovered", 1'b0, NORM, 1'b0, 2'd0, 0, 0);

    // Memory wait interrupting a three-cycle flush
    do_reset();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    expect_c("fw_flush1", 1'b1, FL, 1'b0, 2'd0, 0, 0);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    expect_c("fw_hold1", 1'b1, HOLD, 1'b0, 2'd1, 0, 1);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    expect_c("fw_hold2", 1'b1, HOLD, 1'b0, 2'd2, 1, 1);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    expect_c("fw_flush2", 1'b1, FL, 1'b0, 2'd2, 2, 1);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    expect_c("fw_flush3", 1'b1, FL, 1'b0, 2'd1, 2, 1);
    idle(); expect_c("fw_done", 1'b1, NORM, 1'b0, 2'd0, 2, 1);

    // Drain: any record left unchecked is reported stale by the monitor
    for (int i = 0; i < 3; i++) idle();
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
      errors++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall controller for the 16-bit 5-stage pipeline; the producer side of the stall/bubble interface consumed by the pipeline registers.
- Drives PC write enable, IF/ID write enable and flush, and the ID/EX IDEXWrite bubble control (0 = zero all ID/EX control bits, data still latched).
- Drives a global hold for ID/EX, EX/MEM and MEM/WB during multi-cycle data-memory waits.
- Detects load-use hazards, sequences branch/jump flushes over a configurable number of cycles, times out stuck memory accesses, and keeps saturating performance counters.

Parameters:
FLUSH_CYCLES, 1, consecutive cycles IF/ID is flushed and ID/EX bubbled after a taken branch/jump; legal range 1..3
TIMEOUT, 16, maximum MEM_WAIT cycles before entering ERR; legal range 2..255
CNT_W, 16, width of the performance counters

Ports:
clk_i  in  1  clock
rst_n  in  1  reset; synchronous, active-low
IFID_RSaddr_i  in  3  RS address of the instruction in ID
IFID_RTaddr_i  in  3  RT address of the instruction in ID
IFID_uses_rt_i  in  1  ID instruction reads RT as a source
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_RTaddr_i  in  3  load destination register
EX_taken_i  in  1  branch taken or jump resolved in EX this cycle
MEM_req_i  in  1  EX/MEM holds a load or store
MEM_ready_i  in  1  data memory completes the access this cycle
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID write enable
IFIDFlush_o  out  1  IF/ID clear to NOP
IDEXWrite_o  out  1  0 inserts a bubble into ID/EX
hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
err_o  out  1  memory timeout; sticky until reset
state_o  out  2  current FSM state
stall_cnt_o  out  CNT_W  load-use bubbles plus hold cycles, saturating
flush_cnt_o  out  CNT_W  taken-branch events, saturating

Behaviour:
- States: RUN=0, FLUSH=1, MEM_WAIT=2, ERR=3.
- Registers: state, flush_rem (2 bits), wait_cnt (8 bits), both counters.
- Outputs are combinational from state and inputs (Mealy); all hazard responses take effect in the detection cycle.
- Reset (rst_n=0 at clock edge): state=RUN, flush_rem=0, wait_cnt=0, counters=0, err_o=0.
- Output values while in reset: PCWrite_o=1, IFIDWrite_o=1, IDEXWrite_o=1, IFIDFlush_o=0, hold_o=0.
- Reset mid-operation aborts any flush or wait immediately.
- Definitions:
  - memwait = MEM_req_i & ~MEM_ready_i
  - lu = IDEX_MemRead_i & (IDEX_RTaddr_i!=0) & ((IDEX_RTaddr_i==IFID_RSaddr_i) | (IFID_uses_rt_i & IDEX_RTaddr_i==IFID_RTaddr_i))
- Default outputs: PCWrite_o=1, IFIDWrite_o=1, IDEXWrite_o=1, IFIDFlush_o=0, hold_o=0.
- RUN, priority memwait > EX_taken_i > lu:
  - memwait: PCWrite_o=0, IFIDWrite_o=0, hold_o=1, IDEXWrite_o=1 (hold, not bubble); stall_cnt+1; wait_cnt=1; go MEM_WAIT.
  - EX_taken_i: IFIDFlush_o=1, IDEXWrite_o=0, PCWrite_o=1 (PC loads target); flush_cnt+1.
    - If FLUSH_CYCLES>1: flush_rem=FLUSH_CYCLES-1, go FLUSH.
    - lu is ignored in this cycle.
  - lu: PCWrite_o=0, IFIDWrite_o=0, IDEXWrite_o=0; stall_cnt+1; stay RUN.
    - The next cycle re-evaluates lu; the bubble clears IDEX_MemRead_i, so exactly one bubble results.
- FLUSH:
  - memwait takes precedence exactly as in RUN; flush_rem is preserved.
  - Otherwise: IFIDFlush_o=1, IDEXWrite_o=0, PCWrite_o=1; flush_rem-1; go RUN when flush_rem reaches 0.
  - EX_taken_i and lu are ignored (EX holds a bubble).
- MEM_WAIT:
  - Cycle with MEM_ready_i=0: hold outputs as in RUN memwait; stall_cnt+1; wait_cnt+1.
    - If wait_cnt==TIMEOUT at this edge, go ERR.
  - Cycle with MEM_ready_i=1: hold released; outputs and transitions identical to RUN if flush_rem==0, or to FLUSH if flush_rem>0, evaluated in that same cycle; wait_cnt=0.
- ERR: PCWrite_o=0, IFIDWrite_o=0, IDEXWrite_o=0, hold_o=1, err_o=1; exits only via reset.
- Counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with random inputs -> PCWrite_o=IFIDWrite_o=IDEXWrite_o=1, IFIDFlush_o=0, hold_o=0, state_o=0, both counters 0.
2. Load-use: IDEX_MemRead_i=1, IDEX_RTaddr_i=3, IFID_RSaddr_i=3 -> same cycle PCWrite_o=IFIDWrite_o=IDEXWrite_o=0, stall_cnt 0->1. Repeat with RTaddr=0, or RT match with IFID_uses_rt_i=0 -> no stall.
3. Branch, FLUSH_CYCLES=2: EX_taken_i pulse with lu also true -> IFIDFlush_o=1 and IDEXWrite_o=0 for 2 cycles, PCWrite_o=1, flush_cnt=1, stall_cnt unchanged, state 0->1->0.
4. Memory wait: MEM_req_i=1, MEM_ready_i=0 for 3 cycles, then 1 -> hold_o=1 and PCWrite_o=0 for 3 cycles, state_o=2, stall_cnt=3, RUN outputs in the ready cycle.
5. Timeout, TIMEOUT=4: MEM_ready_i held 0 -> ERR after the 4th wait cycle, err_o=1, freeze persists; rst_n=0 one cycle -> RUN, err_o=0.
6. Wait inside flush, FLUSH_CYCLES=3: memwait arrives on the 2nd flush cycle -> hold 2 cycles; after ready, exactly 2 further flush cycles, then RUN; flush_cnt=1.
